snake_reg_writer: RTL and testbench

SNAKE_REG_WRITER -- requirements
Module: snake_reg_writer

---
 rtl/snake_reg_writer.sv | 155 +++++++++++++++
 tb/tb_snake_reg_writer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_reg_writer.sv
// snake_reg_writer
//   Buffers register-write commands from the game logic in a small FIFO and
//   replays them, in acceptance order, as Avalon-MM write transfers to the
//   display peripheral.
//
//   Optional feature: define SNAKE_WRITER_VBLANK_GATE_EN to allow a new
//   transfer to launch only while vblank=1. A transfer that has already
//   started always runs to completion. With the macro undefined, vblank is
//   ignored.
//
// Ports
//   clk              sole clock, rising edge
//   reset            synchronous, active-high
//   cmd_valid/ready  command handshake (cmd_ready = FIFO not full)
//   cmd_addr[2:0]    register index (0..2 bg r/g/b, 3..6 sprite x/y bytes)
//   cmd_data[7:0]    byte to write
//   vblank           vertical blanking indicator (used only with the gate)
//   avm_*            Avalon-MM master write port
//   fifo_level       number of buffered commands
//   overflow         sticky: cmd_valid seen while cmd_ready was low
module snake_reg_writer #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_addr,
    input  logic [7:0]                   cmd_data,
    input  logic                         vblank,
    output logic                         avm_chipselect,
    output logic                         avm_write,
    output logic [2:0]                   avm_address,
    output logic [7:0]                   avm_writedata,
    input  logic                         avm_waitrequest,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        WRITE
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          full, empty;
    logic          push, pop;
    logic          strobe_q, strobe_d;
    logic          launch_ok;

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);

    // Ready comes purely from the registered level, so a pop on the same
    // edge never makes room for a push.
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;

`ifdef SNAKE_WRITER_VBLANK_GATE_EN
    assign launch_ok = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign launch_ok     = 1'b1;
`endif

    // Next-state and pop decision. pop doubles as "load head into the bus
    // registers", since every pop launches a transfer.
    always_comb begin
        state_d  = state_q;
        strobe_d = strobe_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                strobe_d = 1'b0;
                if (!empty) begin
                    state_d = GATE;
                end
            end
            GATE: begin
                if (launch_ok && !empty) begin
                    pop      = 1'b1;
                    strobe_d = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    if (!empty && launch_ok) begin
                        pop = 1'b1;
                    end else begin
                        strobe_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                strobe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // Storage needs no reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            strobe_q      <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            overflow      <= 1'b0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr                       <= rd_ptr + PTR_ONE;
                {avm_address, avm_writedata} <= mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (cmd_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    assign avm_chipselect = strobe_q;
    assign avm_write      = strobe_q;
    assign fifo_level     = level;

endmodule

// File: tb/tb_snake_reg_writer.sv
// Testbench for snake_reg_writer: table-driven single transfers plus
// hand-written multi-cycle sequences, with a queue scoreboard that records
// accepted commands and compares them against completed bus writes.
module tb_snake_reg_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       vblank;
    logic       avm_chipselect;
    logic       avm_write;
    logic [2:0] avm_address;
    logic [7:0] avm_writedata;
    logic       avm_waitrequest;
    logic [3:0] fifo_level;
    logic       overflow;

    snake_reg_writer #(.FIFO_DEPTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .vblank          (vblank),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .fifo_level      (fifo_level),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard: accepted commands queued, popped on each completed write.
    logic [10:0] sb_q[$];
    int          completions = 0;
    logic        hold_prev = 1'b0;
    logic [2:0]  hold_addr;
    logic [7:0]  hold_data;

    always @(negedge clk) begin
        logic [10:0] exp;
        if (reset) begin
            sb_q.delete();
            hold_prev = 1'b0;
        end else begin
            chk("cs_eq_write", int'(avm_chipselect), int'(avm_write));
            if (hold_prev) begin
                chk("stall_write", int'(avm_write), 1);
                chk("stall_addr", int'(avm_address), int'(hold_addr));
                chk("stall_data", int'(avm_writedata), int'(hold_data));
            end
            hold_prev = avm_write && avm_waitrequest;
            hold_addr = avm_address;
            hold_data = avm_writedata;
            if (avm_write && !avm_waitrequest) begin
                completions++;
                chk("sb_empty_at_write", int'(sb_q.size() == 0), 0);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    chk("sb_addr", int'(avm_address), int'(exp[10:8]));
                    chk("sb_data", int'(avm_writedata), int'(exp[7:0]));
                end
            end
            if (cmd_valid && cmd_ready) begin
                sb_q.push_back({cmd_addr, cmd_data});
            end
        end
    end

    // Push n consecutive commands (addr/data incrementing from a0/d0), hold
    // waitrequest for wait_n cycles of the first write, then measure timing.
    task automatic run_burst(input string tag, input int n, input logic [2:0] a0,
                             input logic [7:0] d0, input int wait_n, input int exp_len);
        int pushed;
        int waits_left;
        int first;
        int cnt;
        int last;
        first      = -1;
        cnt        = 0;
        last       = -1;
        waits_left = wait_n;
        @(posedge clk); #2;
        avm_waitrequest = (wait_n > 0);
        cmd_valid = 1'b1;
        cmd_addr  = a0;
        cmd_data  = d0;
        pushed    = 1;
        @(posedge clk); #2;
        for (int c = 0; c < 30; c++) begin
            cmd_valid = (pushed < n);
            cmd_addr  = a0 + 3'(pushed);
            cmd_data  = d0 + 8'(pushed);
            if (pushed < n) pushed++;
            @(negedge clk);
            if (n == 1 && c <= 2) chk({tag, "_level"}, int'(fifo_level), (c < 2) ? 1 : 0);
            if (avm_write) begin
                if (first < 0) first = c;
                cnt++;
                last = c;
                if (waits_left > 0) waits_left--;
            end
            @(posedge clk); #2;
            avm_waitrequest = (waits_left > 0);
        end
        cmd_valid = 1'b0;
        chk({tag, "_first"}, first, 2);
        chk({tag, "_len"}, cnt, exp_len);
        chk({tag, "_last"}, last, 1 + exp_len);
    endtask

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        int         wait_n;
        int         exp_len;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int acc;
        int maxlvl;
        int comp0;
        int done;

        vecs[0] = '{addr: 3'd0, data: 8'h40, wait_n: 0, exp_len: 1};
        vecs[1] = '{addr: 3'd1, data: 8'hFF, wait_n: 0, exp_len: 1};
        vecs[2] = '{addr: 3'd6, data: 8'h00, wait_n: 4, exp_len: 5};
        vecs[3] = '{addr: 3'd3, data: 8'hA5, wait_n: 1, exp_len: 2};
        vecs[4] = '{addr: 3'd5, data: 8'h5A, wait_n: 2, exp_len: 3};

        reset           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_addr        = '0;
        cmd_data        = '0;
        vblank          = 1'b1;
        avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_write", int'(avm_write), 0);
        chk("rst_cs", int'(avm_chipselect), 0);
        chk("rst_addr", int'(avm_address), 0);
        chk("rst_data", int'(avm_writedata), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_overflow", int'(overflow), 0);

        for (int i = 0; i < 5; i++) begin
            run_burst($sformatf("vec%0d", i), 1, vecs[i].addr, vecs[i].data,
                      vecs[i].wait_n, vecs[i].exp_len);
        end

        run_burst("b2b3", 3, 3'd2, 8'h10, 0, 3);
        run_burst("stall2", 2, 3'd4, 8'h77, 4, 6);

        // Fill with a stalled slave: one entry leaves at launch, so nine are
        // accepted before full and the tenth offer sets overflow.
        @(posedge clk); #2;
        avm_waitrequest = 1'b1;
        acc    = 0;
        maxlvl = 0;
        @(negedge clk);
        chk("ovf_before", int'(overflow), 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            cmd_valid = 1'b1;
            cmd_addr  = 3'(i);
            cmd_data  = 8'(8'hC0 + i);
            @(negedge clk);
            if (cmd_ready) acc++;
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
        end
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        @(negedge clk);
        if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
        chk("full_accepts", acc, 9);
        chk("full_level_max", maxlvl, 8);
        chk("full_level", int'(fifo_level), 8);
        chk("full_ready", int'(cmd_ready), 0);
        chk("full_overflow", int'(overflow), 1);
        comp0 = completions;
        @(posedge clk); #2;
        avm_waitrequest = 1'b0;
        done = 0;
        for (int i = 0; i < 40 && done == 0; i++) begin
            @(negedge clk);
            if (fifo_level == '0 && !avm_write) done = 1;
        end
        chk("drain_done", done, 1);
        chk("drain_count", completions - comp0, 9);
        chk("ovf_sticky", int'(overflow), 1);

        // Reset in the middle of a stalled transfer with three entries queued.
        @(posedge clk); #2;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_addr  = 3'(i + 1);
            cmd_data  = 8'(8'h30 + i);
            @(posedge clk); #2;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_write", int'(avm_write), 1);
        chk("mid_level", int'(fifo_level), 3);
        @(posedge clk); #2;
        reset           = 1'b0;
        cmd_valid       = 1'b0;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        chk("abort_write", int'(avm_write), 0);
        chk("abort_cs", int'(avm_chipselect), 0);
        chk("abort_level", int'(fifo_level), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_overflow", int'(overflow), 0);

        run_burst("after_rst", 1, 3'd2, 8'h99, 0, 1);

`ifdef SNAKE_WRITER_VBLANK_GATE_EN
        @(posedge clk); #2;
        vblank    = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = 3'd1;
        cmd_data  = 8'h42;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (avm_write) acc++;
        end
        chk("gate_no_write", acc, 0);
        chk("gate_level", int'(fifo_level), 1);
        @(posedge clk); #2;
        vblank = 1'b1;
        @(negedge clk);
        chk("gate_still_low", int'(avm_write), 0);
        @(negedge clk);
        chk("gate_launch", int'(avm_write), 1);
        repeat (3) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("sb_leftover", int'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
